// File: rtl/learn_reader.sv
// learn_reader
// Read-back engine for the learned spectrum tables. A start request (only
// honoured while idle and with learn_done high) sweeps the complex-response
// RAM and the modulus RAM from address 0 to NUM_PTS-1. The returned
// {real, imag, modulus} words are streamed out through a small
// first-word-fall-through FIFO on a valid/ready interface with full
// back-pressure. The peak modulus and its address are tracked as words
// enter the FIFO.
//
// Ports:
//   clk_50m, rst_n         clock, asynchronous active-low reset
//   start, learn_done      sweep request (level), tables-complete qualifier
//   rd_en, rd_addr         RAM read strobe and shared read address
//   rd_real/imag/mod       RAM read data, valid RD_LAT clocks after rd_en
//   out_valid, out_ready   output handshake
//   out_real/imag/mod      FIFO head word
//   out_addr, out_last     table address of the head word, last-address flag
//   busy, done             sweep in progress, one-clock completion pulse
//   peak_mod, peak_addr    largest modulus of the current/last sweep, address
module learn_reader #(
    parameter int NUM_PTS    = 2751,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        start,
    input  logic        learn_done,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    input  logic [23:0] rd_real,
    input  logic [23:0] rd_imag,
    input  logic [23:0] rd_mod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_real,
    output logic [23:0] out_imag,
    output logic [23:0] out_mod,
    output logic [11:0] out_addr,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [23:0] peak_mod,
    output logic [11:0] peak_addr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [11:0]   LAST_ADDR = 12'(NUM_PTS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic [11:0]   r_issue_cnt;
    logic [23:0]   r_peak_mod;
    logic [11:0]   r_peak_addr;

    // Credits count every word that will or does occupy the FIFO
    // (reads in flight plus stored words), so a read is only issued when
    // a slot is guaranteed at return time.
    logic [CW-1:0] r_credits;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [RD_LAT-1:0] r_vld;
    logic [11:0]   r_apipe  [RD_LAT];
    logic [23:0]   r_f_real [FIFO_DEPTH];
    logic [23:0]   r_f_imag [FIFO_DEPTH];
    logic [23:0]   r_f_mod  [FIFO_DEPTH];
    logic [11:0]   r_f_addr [FIFO_DEPTH];

    logic w_issue;
    logic w_push;
    logic w_pop;

    // All handshake/strobe outputs are decoded from registers only.
    assign w_issue   = (r_state == S_ISSUE) && (r_credits < DEPTH_C);
    assign w_push    = r_vld[RD_LAT-1];
    assign out_valid = (r_count != CW'(0));
    assign w_pop     = out_valid && out_ready;

    assign rd_en     = w_issue;
    assign rd_addr   = r_issue_cnt;
    assign out_real  = r_f_real[r_rptr];
    assign out_imag  = r_f_imag[r_rptr];
    assign out_mod   = r_f_mod[r_rptr];
    assign out_addr  = r_f_addr[r_rptr];
    // Gated by out_valid so an empty FIFO never shows a stale last flag.
    assign out_last  = out_valid && (r_f_addr[r_rptr] == LAST_ADDR);
    assign busy      = r_busy;
    assign done      = r_done;
    assign peak_mod  = r_peak_mod;
    assign peak_addr = r_peak_addr;

    // Sweep control FSM with busy/done, issue counter and peak tracking.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_issue_cnt <= 12'd0;
            r_peak_mod  <= 24'd0;
            r_peak_addr <= 12'd0;
        end else begin
            r_done <= 1'b0;
            // Strict compare: on a tie the earlier (lower) address is kept.
            if (w_push && (rd_mod > r_peak_mod)) begin
                r_peak_mod  <= rd_mod;
                r_peak_addr <= r_apipe[RD_LAT-1];
            end
            case (r_state)
                S_IDLE: begin
                    if (start && learn_done) begin
                        r_state     <= S_ISSUE;
                        r_busy      <= 1'b1;
                        r_issue_cnt <= 12'd0;
                        r_peak_mod  <= 24'd0;
                        r_peak_addr <= 12'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        // The counter stops on the last address so rd_addr
                        // keeps showing it after the sweep.
                        if (r_issue_cnt == LAST_ADDR) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_issue_cnt <= r_issue_cnt + 12'd1;
                        end
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return pipeline, credit counter and output FIFO.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CW'(0);
            r_count   <= CW'(0);
            r_wptr    <= PW'(0);
            r_rptr    <= PW'(0);
            r_vld     <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_apipe[i] <= 12'd0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_f_real[i] <= 24'd0;
                r_f_imag[i] <= 24'd0;
                r_f_mod[i]  <= 24'd0;
                r_f_addr[i] <= 12'd0;
            end
        end else begin
            r_vld[0]   <= w_issue;
            r_apipe[0] <= r_issue_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_apipe[i] <= r_apipe[i-1];
            end

            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_push) begin
                r_f_real[r_wptr] <= rd_real;
                r_f_imag[r_wptr] <= rd_imag;
                r_f_mod[r_wptr]  <= rd_mod;
                r_f_addr[r_wptr] <= r_apipe[RD_LAT-1];
                r_wptr           <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_learn_reader.sv
`timescale 1ns/1ps
module tb_learn_reader;

    localparam int NP = 8;
    localparam int RL = 2;
    localparam int FD = 4;

    logic        clk_50m = 1'b0;
    logic        rst_n, start, learn_done, out_ready;
    logic        rd_en, out_valid, out_last, busy, done;
    logic [11:0] rd_addr, out_addr, peak_addr;
    logic [23:0] rd_real, rd_imag, rd_mod;
    logic [23:0] out_real, out_imag, out_mod, peak_mod;

    always #10 clk_50m = ~clk_50m;

    learn_reader #(.NUM_PTS(NP), .RD_LAT(RL), .FIFO_DEPTH(FD)) u_dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .learn_done(learn_done),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_real(rd_real), .rd_imag(rd_imag), .rd_mod(rd_mod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_mod(out_mod),
        .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done), .peak_mod(peak_mod), .peak_addr(peak_addr)
    );

    // RAM model: RD_LAT-stage read pipeline
    logic [23:0] mem_real [NP];
    logic [23:0] mem_imag [NP];
    logic [23:0] mem_mod  [NP];
    logic [23:0] p_real [RL];
    logic [23:0] p_imag [RL];
    logic [23:0] p_mod  [RL];
    logic [23:0] tie_tbl [NP] = '{24'd5, 24'd9, 24'd9, 24'd3, 24'd2, 24'd1, 24'd0, 24'd9};

    always @(posedge clk_50m) begin
        p_real[0] <= mem_real[rd_addr[2:0]];
        p_imag[0] <= mem_imag[rd_addr[2:0]];
        p_mod[0]  <= mem_mod[rd_addr[2:0]];
        for (int i = 1; i < RL; i++) begin
            p_real[i] <= p_real[i-1];
            p_imag[i] <= p_imag[i-1];
            p_mod[i]  <= p_mod[i-1];
        end
    end
    assign rd_real = p_real[RL-1];
    assign rd_imag = p_imag[RL-1];
    assign rd_mod  = p_mod[RL-1];

    typedef struct packed {
        logic [11:0] addr;
        logic [23:0] re;
        logic [23:0] im;
        logic [23:0] md;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int iss_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int outst = 0;
    int max_outst = 0;
    bit done_exp = 1'b0;

    logic [136:0] all_outs;
    assign all_outs = {rd_en, rd_addr, out_valid, out_real, out_imag, out_mod, out_addr,
                       out_last, busy, done, peak_mod, peak_addr};

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares every presented word against the scoreboard head
    always @(negedge clk_50m) begin
        word_t e;
        bit acc_last;
        acc_last = 1'b0;
        if (!rst_n) begin
            done_exp = 1'b0;
            outst = 0;
        end else begin
            if (rd_en) begin
                iss_cnt++;
                outst++;
            end
            if (done) done_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected word", 128'(out_addr), 128'(0));
                end else begin
                    e = exp_q[0];
                    check({out_addr, out_real, out_imag, out_mod, out_last} === e,
                          "word", 128'({out_addr, out_real, out_imag, out_mod, out_last}),
                          128'(e));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        outst--;
                        acc_last = e.last;
                    end
                end
            end
            if (outst > max_outst) max_outst = outst;
            if (done || done_exp) check(done === done_exp, "done pulse timing", 128'(done), 128'(done_exp));
            done_exp = acc_last;
        end
    end

    // A push into a full FIFO (without a simultaneous pop) is a design error
    always @(negedge clk_50m) begin
        if (rst_n) begin
            assert (!(u_dut.w_push && !u_dut.w_pop && (u_dut.r_count == 3'(FD))))
                else $error("FAIL fifo overflow push into full FIFO");
        end
    end

    initial begin
        #1000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic load_table(input bit tie);
        for (int i = 0; i < NP; i++) begin
            mem_real[i] = 24'(i);
            mem_imag[i] = 24'd0 - 24'(i);
            mem_mod[i]  = tie ? tie_tbl[i] : 24'(10 * i);
        end
    endtask

    task automatic expect_sweep();
        word_t w;
        for (int i = 0; i < NP; i++) begin
            w.addr = 12'(i);
            w.re   = mem_real[i];
            w.im   = mem_imag[i];
            w.md   = mem_mod[i];
            w.last = (i == NP - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_sweep();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int ticks);
        int d0;
        d0 = done_cnt;
        ticks = 0;
        while (done_cnt == d0 && ticks < budget) begin
            tick(1);
            ticks++;
        end
        check(done_cnt == d0 + 1, "done seen once", 128'(done_cnt - d0), 128'(1));
    endtask

    initial begin
        int n, t, i0, a0, d0;
        rst_n = 1'b0; start = 1'b0; learn_done = 1'b0; out_ready = 1'b0;
        load_table(1'b0);
        tick(3);
        check(all_outs === '0, "reset outputs", 128'(all_outs), 128'(0));
        rst_n = 1'b1;
        tick(2);

        // start without learn_done is ignored
        i0 = iss_cnt;
        start = 1'b1; tick(2); start = 1'b0; tick(5);
        check(iss_cnt == i0, "no rd_en without learn_done", 128'(iss_cnt - i0), 128'(0));
        check(busy == 1'b0, "busy stays 0", 128'(busy), 128'(0));

        // full-rate sweep
        learn_done = 1'b1; out_ready = 1'b1;
        expect_sweep();
        start_sweep();
        check(busy == 1'b1, "busy after start", 128'(busy), 128'(1));
        n = 0;
        while (!out_valid && n < 10) begin
            tick(1);
            n++;
        end
        check(n == RL + 1, "first valid latency", 128'(n), 128'(RL + 1));
        wait_done(50, t);
        check(t == NP + 1, "one word per clock", 128'(t), 128'(NP + 1));
        check(peak_mod == 24'd70 && peak_addr == 12'd7, "peak 70@7",
              128'({peak_mod, peak_addr}), 128'({24'd70, 12'd7}));
        check(busy == 1'b0, "busy cleared", 128'(busy), 128'(0));
        check(rd_addr == 12'd7, "rd_addr holds last", 128'(rd_addr), 128'(7));
        check(exp_q.size() == 0, "all words seen", 128'(exp_q.size()), 128'(0));

        // out_ready toggling every cycle
        tick(2);
        expect_sweep();
        d0 = done_cnt;
        start_sweep();
        for (int k = 0; k < 200 && done_cnt == d0; k++) begin
            out_ready = ~out_ready;
            tick(1);
        end
        out_ready = 1'b1;
        check(done_cnt == d0 + 1, "toggle sweep done", 128'(done_cnt - d0), 128'(1));
        check(exp_q.size() == 0, "toggle no loss", 128'(exp_q.size()), 128'(0));

        // stalled consumer for 20 clocks
        tick(2);
        out_ready = 1'b0;
        expect_sweep();
        i0 = iss_cnt;
        start_sweep();
        tick(20);
        check(iss_cnt - i0 == FD, "reads while stalled", 128'(iss_cnt - i0), 128'(FD));
        check(rd_en == 1'b0, "rd_en low when full", 128'(rd_en), 128'(0));
        check(out_valid && out_addr == 12'd0, "head addr 0 stalled",
              128'({out_valid, out_addr}), 128'({1'b1, 12'd0}));
        out_ready = 1'b1;
        wait_done(50, t);
        check(exp_q.size() == 0, "stall sweep complete", 128'(exp_q.size()), 128'(0));

        // tie table with start pulses during the sweep
        tick(2);
        load_table(1'b1);
        expect_sweep();
        d0 = done_cnt; i0 = iss_cnt;
        start_sweep();
        for (int k = 0; k < 6; k++) begin
            start = ~start;
            tick(1);
        end
        start = 1'b0;
        wait_done(50, t);
        tick(5);
        check(done_cnt - d0 == 1, "single done", 128'(done_cnt - d0), 128'(1));
        check(iss_cnt - i0 == NP, "start ignored while busy", 128'(iss_cnt - i0), 128'(NP));
        check(peak_mod == 24'd9 && peak_addr == 12'd1, "tie keeps lower addr",
              128'({peak_mod, peak_addr}), 128'({24'd9, 12'd1}));

        // reset in the middle of a sweep
        load_table(1'b0);
        expect_sweep();
        a0 = acc_cnt;
        start_sweep();
        n = 0;
        while (acc_cnt - a0 < 3 && n < 50) begin
            tick(1);
            n++;
        end
        check(acc_cnt - a0 == 3, "reached word 3", 128'(acc_cnt - a0), 128'(3));
        #3 rst_n = 1'b0;
        #1;
        check(all_outs === '0, "async reset outputs", 128'(all_outs), 128'(0));
        exp_q.delete();
        d0 = done_cnt;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check(done_cnt == d0, "no done after abort", 128'(done_cnt - d0), 128'(0));
        expect_sweep();
        start_sweep();
        wait_done(50, t);
        check(exp_q.size() == 0, "replay after reset", 128'(exp_q.size()), 128'(0));
        check(peak_mod == 24'd70 && peak_addr == 12'd7, "peak after replay",
              128'({peak_mod, peak_addr}), 128'({24'd70, 12'd7}));
        check(max_outst <= FD, "outstanding bound", 128'(max_outst), 128'(FD));

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
